// File: rtl/jt900h_blkseq_if.sv
// Handshake bundle around the TLCS-900H block transfer/search sequencer.
// The master side is the sequencer itself. The slave side is the
// decoder, the index address unit and memory.
interface jt900h_blkseq_if;
    // Decoder request
    logic        start;
    logic [1:0]  kind;
    logic        rep;
    logic        wsize;
    logic [15:0] bc_init;
    logic [15:0] cmp_val;
    logic        abort;

    // Index address unit handshake
    logic        idx_en;
    logic        use_last;
    logic        ldd_write;
    logic        idx_ok;
    logic [23:0] idx_addr;

    // Memory request and response
    logic [23:0] mem_addr;
    logic        mem_rd;
    logic        mem_we;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;

    // Results back to the register bank and flags
    logic [15:0] bc;
    logic        bc_we;
    logic        flag_v;
    logic        flag_z;
    logic        busy;
    logic        done;

    modport master (
        input  start, kind, rep, wsize, bc_init, cmp_val, abort,
        input  idx_ok, idx_addr, mem_rdata, mem_ack,
        output idx_en, use_last, ldd_write,
        output mem_addr, mem_rd, mem_we, mem_wdata,
        output bc, bc_we, flag_v, flag_z, busy, done
    );

    modport slave (
        output start, kind, rep, wsize, bc_init, cmp_val, abort,
        output idx_ok, idx_addr, mem_rdata, mem_ack,
        input  idx_en, use_last, ldd_write,
        input  mem_addr, mem_rd, mem_we, mem_wdata,
        input  bc, bc_we, flag_v, flag_z, busy, done
    );
endinterface

// File: rtl/jt900h_blkseq.sv
// Block transfer/search sequencer for LDI/LDD/CPI/CPD and their repeat forms.
// Each iteration fetches an address from the index unit, reads one element,
// writes it back for LD kinds, then decrements BC and updates V/Z.
module jt900h_blkseq (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cen,
    jt900h_blkseq_if.master bus
);
    typedef enum logic [2:0] {IDLE, ADDR, RD, WR, UPD, FIN} state_t;
    typedef enum logic [1:0] {WR_LDD, WR_FIRST, WR_HOLD} wrPhase_t;

    state_t      state_q, state_d;
    wrPhase_t    wrPhase_q, wrPhase_d;
    logic        isCp_q, isCp_d;
    logic        rep_q, rep_d;
    logic        wsize_q, wsize_d;
    logic [15:0] cmpVal_q, cmpVal_d;
    logic [15:0] count_q, count_d;
    logic [23:0] srcAddr_q, srcAddr_d;
    logic [23:0] dstAddr_q, dstAddr_d;
    logic [15:0] data_q, data_d;
    logic        notFirst_q, notFirst_d;
    logic        flagV_q, flagV_d;
    logic        flagZ_q, flagZ_d;

    logic [15:0] newCount;
    logic        newV;
    logic        dataMatch;

    logic        idxEn, useLast, lddWrite;
    logic [23:0] memAddr;
    logic        memRd, memWe;
    logic [15:0] bcOut;
    logic        bcWe, flagVOut, flagZOut;

    // Outcome of the element in flight: the decremented count and whether the
    // data matched the compare value (only the low byte counts in byte mode).
    always_comb begin
        newCount = count_q - 16'd1;
        newV     = (newCount != 16'd0);
        if (wsize_q) begin
            dataMatch = isCp_q && (data_q == cmpVal_q);
        end else begin
            dataMatch = isCp_q && (data_q[7:0] == cmpVal_q[7:0]);
        end
    end

    // Next-state and output decode. Nothing advances without cen, so pulses
    // last one cen cycle. Strobes are only honoured in the state that asks.
    always_comb begin
        state_d    = state_q;
        wrPhase_d  = wrPhase_q;
        isCp_d     = isCp_q;
        rep_d      = rep_q;
        wsize_d    = wsize_q;
        cmpVal_d   = cmpVal_q;
        count_d    = count_q;
        srcAddr_d  = srcAddr_q;
        dstAddr_d  = dstAddr_q;
        data_d     = data_q;
        notFirst_d = notFirst_q;
        flagV_d    = flagV_q;
        flagZ_d    = flagZ_q;

        idxEn    = 1'b0;
        useLast  = 1'b0;
        lddWrite = 1'b0;
        memAddr  = 24'd0;
        memRd    = 1'b0;
        memWe    = 1'b0;
        bcOut    = count_q;
        bcWe     = 1'b0;
        flagVOut = flagV_q;
        flagZOut = flagZ_q;

        case (state_q)
            IDLE: begin
                if (cen && bus.start) begin
                    isCp_d     = bus.kind[1];
                    rep_d      = bus.rep;
                    wsize_d    = bus.wsize;
                    cmpVal_d   = bus.cmp_val;
                    count_d    = bus.bc_init;
                    notFirst_d = 1'b0;
                    state_d    = ADDR;
                end
            end
            ADDR: begin
                idxEn   = 1'b1;
                useLast = notFirst_q;
                if (cen && bus.idx_ok) begin
                    srcAddr_d = bus.idx_addr;
                    state_d   = RD;
                end
            end
            RD: begin
                memRd   = 1'b1;
                memAddr = srcAddr_q;
                if (cen && bus.mem_ack) begin
                    data_d    = wsize_q ? bus.mem_rdata : {8'h00, bus.mem_rdata[7:0]};
                    wrPhase_d = WR_LDD;
                    state_d   = isCp_q ? UPD : WR;
                end
            end
            WR: begin
                case (wrPhase_q)
                    WR_LDD: begin
                        lddWrite = 1'b1;
                        if (cen) begin
                            wrPhase_d = WR_FIRST;
                        end
                    end
                    WR_FIRST: begin
                        // The index unit presents XDE now; pass it straight
                        // through and keep a copy in case memory stalls.
                        memWe   = 1'b1;
                        memAddr = bus.idx_addr;
                        if (cen) begin
                            dstAddr_d = bus.idx_addr;
                            if (bus.mem_ack) begin
                                state_d = UPD;
                            end else begin
                                wrPhase_d = WR_HOLD;
                            end
                        end
                    end
                    WR_HOLD: begin
                        memWe   = 1'b1;
                        memAddr = dstAddr_q;
                        if (cen && bus.mem_ack) begin
                            state_d = UPD;
                        end
                    end
                    default: begin
                        wrPhase_d = WR_LDD;
                    end
                endcase
            end
            UPD: begin
                bcOut    = newCount;
                bcWe     = 1'b1;
                flagVOut = newV;
                flagZOut = dataMatch;
                if (cen) begin
                    count_d = newCount;
                    flagV_d = newV;
                    flagZ_d = dataMatch;
                    if (rep_q && newV && !dataMatch && !bus.abort) begin
                        notFirst_d = 1'b1;
                        state_d    = ADDR;
                    end else begin
                        state_d = FIN;
                    end
                end
            end
            FIN: begin
                if (cen) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any sequence in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wrPhase_q  <= WR_LDD;
            isCp_q     <= 1'b0;
            rep_q      <= 1'b0;
            wsize_q    <= 1'b0;
            cmpVal_q   <= 16'd0;
            count_q    <= 16'd0;
            srcAddr_q  <= 24'd0;
            dstAddr_q  <= 24'd0;
            data_q     <= 16'd0;
            notFirst_q <= 1'b0;
            flagV_q    <= 1'b0;
            flagZ_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wrPhase_q  <= wrPhase_d;
            isCp_q     <= isCp_d;
            rep_q      <= rep_d;
            wsize_q    <= wsize_d;
            cmpVal_q   <= cmpVal_d;
            count_q    <= count_d;
            srcAddr_q  <= srcAddr_d;
            dstAddr_q  <= dstAddr_d;
            data_q     <= data_d;
            notFirst_q <= notFirst_d;
            flagV_q    <= flagV_d;
            flagZ_q    <= flagZ_d;
        end
    end

    assign bus.idx_en    = idxEn;
    assign bus.use_last  = useLast;
    assign bus.ldd_write = lddWrite;
    assign bus.mem_addr  = memAddr;
    assign bus.mem_rd    = memRd;
    assign bus.mem_we    = memWe;
    assign bus.mem_wdata = data_q;
    assign bus.bc        = bcOut;
    assign bus.bc_we     = bcWe;
    assign bus.flag_v    = flagVOut;
    assign bus.flag_z    = flagZOut;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == FIN);
endmodule

// File: doc/jt900h_blkseq.md
# jt900h_blkseq

Sequencer for the TLCS-900H block transfer/search instructions (LDI/LDD/CPI/CPD and the repeat forms LDIR/LDDR/CPIR/CPDR). It sits between the instruction decoder and the index address unit. It drives that unit's `idx_en`/`use_last`/`ldd_write` handshake, runs the memory read and write for each element, decrements the BC count and produces the V/Z flag results. One element is processed per iteration; the repeat forms loop without re-fetching the opcode.

## Interface
- No parameters.
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `cen` in 1: clock enable. All state advances only when `cen=1`.
- `start` in 1: one-cycle request, sampled on a `cen` cycle while `busy=0`.
- `kind` in 2: 0 LDI, 1 LDD, 2 CPI, 3 CPD. Sampled with `start`.
- `rep` in 1: repeat form. Sampled with `start`.
- `wsize` in 1: 0 byte, 1 word. Sampled with `start`.
- `bc_init` in 16: BC value at `start`.
- `cmp_val` in 16: A (byte) or WA (word) for CP kinds. Sampled with `start`.
- `abort` in 1: pending interrupt; stops a repeat at the next iteration boundary.
- `idx_en` out 1, `use_last` out 1, `ldd_write` out 1: control to the index address unit.
- `idx_ok` in 1, `idx_addr` in 24: address-ready strobe and the address from the index address unit.
- `mem_addr` out 24, `mem_rd` out 1, `mem_we` out 1, `mem_wdata` out 16: memory request.
- `mem_rdata` in 16, `mem_ack` in 1: memory response.
- `bc` out 16, `bc_we` out 1: updated count and its register-bank write strobe.
- `flag_v` out 1: result V flag (BC≠0).
- `flag_z` out 1: result Z flag (match, CP kinds only).
- `busy` out 1: sequence in progress.
- `done` out 1: one-cycle completion pulse.

## Operation
- States: IDLE, ADDR, RD, WR, UPD, FIN.
- IDLE:
  - `start` latches `kind`/`rep`/`wsize`/`cmp_val`, loads the count from `bc_init`, and goes to ADDR with `use_last=0`.
  - `start` while `busy=1` is ignored.
- ADDR:
  - Holds `idx_en=1` until `idx_ok=1`, then latches `idx_addr` as the source address and goes to RD.
  - `use_last=1` on every iteration after the first.
- RD:
  - Holds `mem_rd=1` with `mem_addr`=source until `mem_ack`, then latches `mem_rdata` (byte: low 8 bits, upper 8 bits zero).
  - LD kinds go to WR; CP kinds go to UPD.
- WR:
  - First cycle: `ldd_write=1` for one `cen` cycle, so the unit loads the destination (XDE) address.
  - Next cycle: samples `idx_addr` as `mem_addr`, then holds `mem_we=1` with `mem_wdata`=latched data until `mem_ack`, then goes to UPD.
- UPD:
  - count ← count−1 (mod 2^16); `bc_we=1` for one cycle with the new count on `bc`.
  - `flag_v` = (new count ≠ 0).
  - CP kinds: `flag_z` = (data == `cmp_val` masked to size). LD kinds: `flag_z`=0.
  - Loop to ADDR when `rep` & `flag_v` & !(CP & `flag_z`) & !`abort`. Otherwise go to FIN.
- FIN: `done=1` for one `cen` cycle, then IDLE.
- `bc_init=0` with `rep=1` runs 65536 iterations: the count wraps 0→FFFF and the loop continues.
- `abort` is sampled only in UPD. The aborted repeat ends with the correct BC and flags, so the decoder can re-execute it after the interrupt.

## Timing
- Reset values: every output 0. Internal state IDLE, count 0, latches 0.
- `busy` is 1 in every state except IDLE, including FIN.
- `start` → `idx_en=1` on the next `cen` edge.
- Minimum iteration, zero-wait memory with `idx_ok` and `mem_ack` in the first cycle:
  - LD: ADDR 1, RD 1, WR 2, UPD 1 = 5 `cen` cycles.
  - CP: 3 `cen` cycles.
- `idx_ok`/`mem_ack` are only honoured while the matching request is high. Strobes arriving in other states are ignored.
- `mem_rd` and `mem_we` are never high together. Address and data stay stable while a request is pending.
- `cen=0`: all outputs hold. Pulse outputs (`bc_we`, `ldd_write`, `done`) last exactly one `cen` cycle.
- `rst_n` low mid-sequence: immediate return to IDLE with all outputs 0. No partial BC write is issued.

## Test plan
- LDI byte, `bc_init`=3, `rep`=0, zero-wait memory → one read and one write, `bc`=2, `flag_v`=1, `done` five `cen` cycles after `idx_en` rose.
- LDIR word, `bc_init`=4 → four read/write pairs, `use_last` 0 on the first iteration and 1 after, final `bc`=0, `flag_v`=0, one `done`.
- CPIR byte, `cmp_val`=0x5A, data 11,22,5A,33, `bc_init`=10 → stops after the third read, `bc`=7, `flag_z`=1, `flag_v`=1, no `mem_we` ever.
- LDDR, `bc_init`=0, stimulus runs for 3 iterations → `bc` sequence FFFF, FFFE, FFFD; then `abort`=1 at UPD → FIN with `bc`=FFFC, `flag_v`=1.
- Memory with 3 wait cycles and `cen` toggling every other clock → `mem_addr`/`mem_wdata` stable throughout, correct results, pulses one `cen` cycle wide.
- `rst_n` low during WR of LDIR → all outputs 0 asynchronously; new `start` after release begins cleanly with `use_last`=0.
